// File: rtl/vram_pkg.sv
// Shared definitions for the scaled RGB video RAM: address sizing,
// controller states and the scan-out counter record.
package vram_pkg;

  localparam int CNT_W   = 16;
  localparam int SCAN_AW = 24;

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } vram_state_e;

  // rd_addr and row_base are wider than any legal frame so the
  // sequencer arithmetic never wraps before it is clamped.
  typedef struct packed {
    logic [CNT_W-1:0]   sub_x;
    logic [CNT_W-1:0]   sub_y;
    logic [CNT_W-1:0]   col;
    logic [CNT_W-1:0]   row;
    logic [SCAN_AW-1:0] row_base;
    logic [SCAN_AW-1:0] rd_addr;
  } scan_t;

endpackage

// File: rtl/vram_sdp_mem.sv
// Simple dual-port synchronous RAM, one write and one read port on the same
// clock; a same-address read and write returns the previous contents.
module vram_sdp_mem #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 12288,
  parameter int AW    = 14
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vram_scaled_rgb.sv
// Writable 1-bit-per-channel frame store with self-fill after reset and a
// scan-out sequencer that replicates each stored pixel SCALE x SCALE.
//
//   state   | meaning
//   ST_FILL | writing FILL_VALUE to every word, host port closed, rgb forced 0
//   ST_RUN  | host writes accepted, scan-out returns stored pixels
module vram_scaled_rgb
  import vram_pkg::*;
#(
  parameter int                  CHANNELS   = 3,
  parameter int                  H_PIX      = 128,
  parameter int                  V_PIX      = 96,
  parameter int                  SCALE      = 5,
  parameter logic [CHANNELS-1:0] FILL_VALUE = '0,
  parameter int                  ADDR_W     = addr_width(H_PIX * V_PIX)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                pix_en,
  output logic [CHANNELS-1:0] rgb,
  output logic                rgb_valid,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [CHANNELS-1:0] wr_data,
  output logic                wr_ready,
  output logic                wr_err,
  output logic                init_done
);

  localparam int DEPTH = H_PIX * V_PIX;

  localparam logic [CNT_W-1:0]   SCALE_M1  = CNT_W'(SCALE - 1);
  localparam logic [CNT_W-1:0]   H_LAST    = CNT_W'(H_PIX - 1);
  localparam logic [CNT_W-1:0]   H_END     = CNT_W'(H_PIX);
  localparam logic [CNT_W-1:0]   V_LAST    = CNT_W'(V_PIX - 1);
  localparam logic [CNT_W-1:0]   V_END     = CNT_W'(V_PIX);
  localparam logic [SCAN_AW-1:0] H_STEP    = SCAN_AW'(H_PIX);
  localparam logic [ADDR_W-1:0]  FILL_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]    DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  vram_state_e         state_q, state_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  scan_t               scan_q, scan_d, scan_rl;
  logic                rd_ok_q, rd_ok_d;
  logic                rgb_valid_q, rgb_valid_d;
  logic                wr_err_q, wr_err_d;

  logic                run;
  logic                in_range;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [CHANNELS-1:0] mem_wdata;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [CHANNELS-1:0] mem_rdata;

  assign run      = (state_q == ST_RUN);
  assign in_range = ({1'b0, wr_addr} < DEPTH_X);

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    if (state_q == ST_FILL) begin
      fill_addr_d = fill_addr_q + 1'b1;
      if (fill_addr_q == FILL_LAST) begin
        state_d     = ST_RUN;
        fill_addr_d = '0;
      end
    end
  end

  // The fill sequence owns the write port; a host write in that window is
  // simply not accepted rather than queued.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!reset) begin
      if (state_q == ST_FILL) begin
        mem_we    = 1'b1;
        mem_waddr = fill_addr_q;
        mem_wdata = FILL_VALUE;
      end else if (wr_en && in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_comb begin
    wr_err_d = run && wr_en && !in_range;
  end

  // Line/frame reloads first, then the pixel step works on the reloaded copy.
  always_comb begin
    scan_rl = scan_q;
    if (frame_start) begin
      scan_rl = '0;
    end else if (line_start) begin
      scan_rl.sub_x = '0;
      scan_rl.col   = '0;
      if (scan_q.sub_y == SCALE_M1) begin
        scan_rl.sub_y = '0;
        if (scan_q.row < V_END) begin
          scan_rl.row = scan_q.row + 1'b1;
        end
        if (scan_q.row < V_LAST) begin
          scan_rl.row_base = scan_q.row_base + H_STEP;
        end
      end else begin
        scan_rl.sub_y = scan_q.sub_y + 1'b1;
      end
      scan_rl.rd_addr = scan_rl.row_base;
    end
  end

  always_comb begin
    scan_d = scan_rl;
    if (pix_en) begin
      if (scan_rl.sub_x == SCALE_M1) begin
        scan_d.sub_x = '0;
        if (scan_rl.col < H_END) begin
          scan_d.col = scan_rl.col + 1'b1;
        end
        // rd_addr parks on the row's last word once the line overruns.
        if (scan_rl.col < H_LAST) begin
          scan_d.rd_addr = scan_rl.rd_addr + 1'b1;
        end
      end else begin
        scan_d.sub_x = scan_rl.sub_x + 1'b1;
      end
    end
  end

  always_comb begin
    mem_raddr   = scan_rl.rd_addr[ADDR_W-1:0];
    rgb_valid_d = pix_en;
    rd_ok_d     = pix_en && run && (scan_rl.col < H_END) && (scan_rl.row < V_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      fill_addr_q <= '0;
      scan_q      <= '0;
      rd_ok_q     <= 1'b0;
      rgb_valid_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      scan_q      <= scan_d;
      rd_ok_q     <= rd_ok_d;
      rgb_valid_q <= rgb_valid_d;
      wr_err_q    <= wr_err_d;
    end
  end

  vram_sdp_mem #(
    .WIDTH (CHANNELS),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign rgb       = rd_ok_q ? mem_rdata : '0;
  assign rgb_valid = rgb_valid_q;
  assign wr_err    = wr_err_q;
  assign wr_ready  = run;
  assign init_done = run;

endmodule
